jtcontra_colmix_n: RTL and testbench

- Parametrised successor to the two-layer 007593-style colour mixer.
- Resolves priority across LAYERS tile/sprite layers, with a per-layer enable mask and a backdrop code.
- Fetches the 16-bit palette entry for the winning code as two byte reads from a single-clock dual-port palette RAM, then outputs blanked 5-bit RGB.
- Sits between the GFX layer generators and the video output stage; the CPU reads and writes the palette through the same clock domain.

---
 rtl/jtcontra_colmix_pkg.sv | 25 ++
 rtl/jtcontra_colmix_prio.sv | 24 ++
 rtl/jtframe_dual_ram.sv | 27 ++
 rtl/jtcontra_colmix_n.sv | 158 +++++++++++++++
 tb/tb_jtcontra_colmix_n.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/jtcontra_colmix_pkg.sv
// Shared types, colour-field positions and colour-word unpacking for the
// parametrised Contra-style colour mixer.
package jtcontra_colmix_pkg;

  // Palette fetch sequencer: address low byte, address high byte, collect high byte
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    WAIT = 2'd3
  } fetch_state_t;

  // Bit positions of the colour fields inside the 16-bit word {hi,lo}
  localparam int RED_MSB    = 4;
  localparam int GRN_LO_LSB = 5;
  localparam int GRN_HI_MSB = 9;
  localparam int BLU_LSB    = 10;
  localparam int BLU_MSB    = 14;

  // Unpack {hi,lo} into {blue,green,red}; bit 15 carries no colour information
  function automatic logic [14:0] unpackColor(input logic [15:0] word);
    return {word[BLU_MSB:BLU_LSB], word[GRN_HI_MSB:GRN_LO_LSB], word[RED_MSB:0]};
  endfunction

endpackage

// File: rtl/jtcontra_colmix_prio.sv
// Layer priority encoder: the lowest-numbered enabled, opaque layer wins,
// otherwise the backdrop code is used.
module jtcontra_colmix_prio #(
  parameter int LAYERS      = 2,
  parameter int PXLW        = 7,
  parameter int TRANSP_BITS = 4
) (
  input  logic [LAYERS*PXLW-1:0] layer_pxl_i,
  input  logic [LAYERS-1:0]      layer_en_i,
  input  logic [PXLW-1:0]        bg_code_i,
  output logic [PXLW-1:0]        code_o
);

  // Walk from the lowest priority up so the last opaque layer seen (lowest index) wins
  always_comb begin
    code_o = bg_code_i;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (layer_en_i[i] && (layer_pxl_i[i*PXLW +: TRANSP_BITS] != '0)) begin
        code_o = layer_pxl_i[i*PXLW +: PXLW];
      end
    end
  end

endmodule

// File: rtl/jtframe_dual_ram.sv
// Dual-port byte RAM, both ports on one clock, read-first on every port.
module jtframe_dual_ram #(
  parameter int dw = 8,
  parameter int aw = 10
) (
  input  logic          clk,
  input  logic [dw-1:0] data0,
  input  logic [aw-1:0] addr0,
  input  logic          we0,
  output logic [dw-1:0] q0,
  input  logic [dw-1:0] data1,
  input  logic [aw-1:0] addr1,
  input  logic          we1,
  output logic [dw-1:0] q1
);

  logic [dw-1:0] mem [2**aw];

  // Both ports read the old contents before any write in the same clock lands
  always_ff @(posedge clk) begin
    q0 <= mem[addr0];
    q1 <= mem[addr1];
    if (we0) mem[addr0] <= data0;
    if (we1) mem[addr1] <= data1;
  end

endmodule

// File: rtl/jtcontra_colmix_n.sv
// Parametrised colour mixer: picks the winning layer code, fetches its 16-bit
// palette entry as two byte reads and drives blanked 5-bit RGB one pixel later.
module jtcontra_colmix_n
  import jtcontra_colmix_pkg::*;
#(
  parameter int LAYERS      = 2,
  parameter int PXLW        = 7,
  parameter int TRANSP_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pxl_cen,
  input  logic                   LHBL,
  input  logic                   LVBL,
  output logic                   LHBL_dly,
  output logic                   LVBL_dly,
  input  logic                   pal_cs,
  input  logic                   cpu_rnw,
  input  logic                   cpu_cen,
  input  logic [PXLW:0]          cpu_addr,
  input  logic [7:0]             cpu_dout,
  output logic [7:0]             pal_dout,
  input  logic [LAYERS*PXLW-1:0] layer_pxl,
  input  logic [LAYERS-1:0]      layer_en,
  input  logic [PXLW-1:0]        bg_code,
  output logic [4:0]             red,
  output logic [4:0]             green,
  output logic [4:0]             blue,
  output logic                   fetch_err
);

  localparam int AW = PXLW + 1;

  fetch_state_t   state_q, state_d;
  logic [PXLW-1:0] winner;
  logic [PXLW-1:0] code_q;
  logic [AW-1:0]   vidAddr;
  logic [7:0]      vidData;
  logic [7:0]      cpuData;
  logic            cpuWe;
  logic            loadLo;
  logic            loadWord;
  logic [7:0]      loByte_q;
  logic [15:0]     word_q;
  logic [1:0]      blank1_q;
  logic [14:0]     rgb_q;
  logic            hblDly_q;
  logic            vblDly_q;
  logic            err_q;
  logic            palEn_q;

  jtcontra_colmix_prio #(
    .LAYERS      (LAYERS),
    .PXLW        (PXLW),
    .TRANSP_BITS (TRANSP_BITS)
  ) u_prio (
    .layer_pxl_i (layer_pxl),
    .layer_en_i  (layer_en),
    .bg_code_i   (bg_code),
    .code_o      (winner)
  );

  assign cpuWe = cpu_cen & pal_cs & ~cpu_rnw;

  jtframe_dual_ram #(
    .dw (8),
    .aw (AW)
  ) u_ram (
    .clk   (clk),
    .data0 (cpu_dout),
    .addr0 (cpu_addr),
    .we0   (cpuWe),
    .q0    (cpuData),
    .data1 (8'd0),
    .addr1 (vidAddr),
    .we1   (1'b0),
    .q1    (vidData)
  );

  // Fetch state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A pixel strobe always (re)starts the fetch; otherwise step through the byte reads
  always_comb begin
    state_d = state_q;
    if (pxl_cen) begin
      state_d = LO;
    end else begin
      case (state_q)
        LO:      state_d = HI;
        HI:      state_d = WAIT;
        WAIT:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Video-port address and byte capture strobes; an interrupted fetch never assembles
  always_comb begin
    vidAddr  = {code_q, 1'b1};
    loadLo   = 1'b0;
    loadWord = 1'b0;
    case (state_q)
      LO:      vidAddr  = {code_q, 1'b0};
      HI:      loadLo   = 1'b1;
      WAIT:    loadWord = ~pxl_cen;
      default: ;
    endcase
  end

  // Collect the two palette bytes into the colour word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loByte_q <= '0;
      word_q   <= '0;
    end else begin
      if (loadLo)   loByte_q <= vidData;
      if (loadWord) word_q   <= {vidData, loByte_q};
    end
  end

  // Pixel-rate pipeline: latch the new code and blanking, present the previous colour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q   <= '0;
      blank1_q <= '0;
      rgb_q    <= '0;
      hblDly_q <= 1'b0;
      vblDly_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (pxl_cen) begin
      code_q   <= winner;
      blank1_q <= {LHBL, LVBL};
      rgb_q    <= (&blank1_q) ? unpackColor(word_q) : '0;
      hblDly_q <= blank1_q[1];
      vblDly_q <= blank1_q[0];
      if (state_q != IDLE) err_q <= 1'b1;
    end
  end

  // The RAM read register has no reset, so its output is masked until the first clock after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) palEn_q <= 1'b0;
    else        palEn_q <= 1'b1;
  end

  assign pal_dout  = cpuData & {8{palEn_q}};
  assign red       = rgb_q[4:0];
  assign green     = rgb_q[9:5];
  assign blue      = rgb_q[14:10];
  assign LHBL_dly  = hblDly_q;
  assign LVBL_dly  = vblDly_q;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_jtcontra_colmix_n.sv
// Scoreboard bench for jtcontra_colmix_n: expected colours are queued at each
// pixel strobe and compared when the following strobe presents them.
module tb_jtcontra_colmix_n;

  localparam int LAYERS = 2;
  localparam int PXLW   = 7;

  typedef struct packed {
    logic [14:0] rgb;
    logic        hbl;
    logic        vbl;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   pxl_cen;
  logic                   LHBL, LVBL;
  logic                   LHBL_dly, LVBL_dly;
  logic                   pal_cs, cpu_rnw, cpu_cen;
  logic [PXLW:0]          cpu_addr;
  logic [7:0]             cpu_dout, pal_dout;
  logic [LAYERS*PXLW-1:0] layer_pxl;
  logic [LAYERS-1:0]      layer_en;
  logic [PXLW-1:0]        bg_code;
  logic [4:0]             red, green, blue;
  logic                   fetch_err;

  exp_t        sb[$];
  logic [7:0]  palModel [256];
  logic [14:0] modelWord;
  int          assertCount = 0;
  int          failCount   = 0;

  jtcontra_colmix_n #(.LAYERS(LAYERS), .PXLW(PXLW), .TRANSP_BITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pxl_cen   (pxl_cen),
    .LHBL      (LHBL),
    .LVBL      (LVBL),
    .LHBL_dly  (LHBL_dly),
    .LVBL_dly  (LVBL_dly),
    .pal_cs    (pal_cs),
    .cpu_rnw   (cpu_rnw),
    .cpu_cen   (cpu_cen),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .pal_dout  (pal_dout),
    .layer_pxl (layer_pxl),
    .layer_en  (layer_en),
    .bg_code   (bg_code),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .fetch_err (fetch_err)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts every check and reports mismatches
  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [6:0] modelWinner(input logic [13:0] pxl, input logic [1:0] en,
                                             input logic [6:0] bg);
    if (en[0] && pxl[3:0] != 4'd0)  return pxl[6:0];
    if (en[1] && pxl[10:7] != 4'd0) return pxl[13:7];
    return bg;
  endfunction

  function automatic logic [14:0] modelColor(input logic [6:0] code);
    logic [7:0] lo, hi;
    logic [4:0] r, g, b;
    lo = palModel[{code, 1'b0}];
    hi = palModel[{code, 1'b1}];
    r  = lo[4:0];
    g  = {hi[1:0], lo[7:5]};
    b  = hi[6:2];
    return {b, g, r};
  endfunction

  task cpuWrite(input logic [7:0] addr, input logic [7:0] data);
    pal_cs   = 1'b1;
    cpu_rnw  = 1'b0;
    cpu_cen  = 1'b1;
    cpu_addr = addr;
    cpu_dout = data;
    tick();
    pal_cs   = 1'b0;
    cpu_rnw  = 1'b1;
    cpu_cen  = 1'b0;
    palModel[addr] = data;
  endtask

  // Drive one pixel strobe, check the previous pixel's output, queue this pixel's result
  task applyStimulus(input logic [6:0] c0, input logic [6:0] c1, input logic [1:0] en,
                     input logic [6:0] bg, input logic hbl, input logic vbl,
                     input int spacing, input logic collide, input logic [7:0] colData);
    exp_t        e;
    logic [6:0]  w;
    logic [14:0] col;
    layer_pxl = {c1, c0};
    layer_en  = en;
    bg_code   = bg;
    LHBL      = hbl;
    LVBL      = vbl;
    w   = modelWinner({c1, c0}, en, bg);
    col = modelColor(w);
    pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      checkOutput("rgb", 32'({blue, green, red}), 32'(e.rgb));
      checkOutput("LHBL_dly", 32'(LHBL_dly), 32'(e.hbl));
      checkOutput("LVBL_dly", 32'(LVBL_dly), 32'(e.vbl));
    end
    if (spacing >= 4) modelWord = col;
    e.rgb = (hbl && vbl) ? modelWord : 15'd0;
    e.hbl = hbl;
    e.vbl = vbl;
    sb.push_back(e);
    if (collide) begin
      pal_cs   = 1'b1;
      cpu_rnw  = 1'b0;
      cpu_cen  = 1'b1;
      cpu_addr = {w, 1'b0};
      cpu_dout = colData;
      tick();
      palModel[{w, 1'b0}] = colData;
      pal_cs  = 1'b0;
      cpu_rnw = 1'b1;
      cpu_cen = 1'b0;
      tick();
      checkOutput("pal_dout_after_collision", 32'(pal_dout), 32'(colData));
      repeat (spacing - 3) tick();
    end else begin
      repeat (spacing - 1) tick();
    end
  endtask

  // Main sequence
  initial begin
    rst_n     = 1'b0;
    pxl_cen   = 1'b0;
    LHBL      = 1'b1;
    LVBL      = 1'b1;
    pal_cs    = 1'b0;
    cpu_rnw   = 1'b1;
    cpu_cen   = 1'b0;
    cpu_addr  = '0;
    cpu_dout  = '0;
    layer_pxl = '0;
    layer_en  = '0;
    bg_code   = '0;
    modelWord = '0;
    repeat (3) tick();
    checkOutput("reset_rgb", 32'({blue, green, red}), 32'd0);
    checkOutput("reset_LHBL_dly", 32'(LHBL_dly), 32'd0);
    checkOutput("reset_LVBL_dly", 32'(LVBL_dly), 32'd0);
    checkOutput("reset_fetch_err", 32'(fetch_err), 32'd0);
    checkOutput("reset_pal_dout", 32'(pal_dout), 32'd0);
    rst_n = 1'b1;
    sb.push_back('0);

    for (int a = 0; a < 256; a++) cpuWrite(8'(a), 8'($urandom));
    cpuWrite(8'h0A, 8'h1F);
    cpuWrite(8'h0B, 8'h7C);
    cpu_addr = 8'h0B;
    tick();
    checkOutput("cpu_read_0B", 32'(pal_dout), 32'h7C);

    // Palette decode through layer 0, then priority and backdrop cases
    applyStimulus(7'h05, 7'h00, 2'b11, 7'h00, 1'b1, 1'b1, 4, 1'b0, 8'h00);
    applyStimulus(7'h10, 7'h23, 2'b11, 7'h00, 1'b1, 1'b1, 4, 1'b0, 8'h00);
    checkOutput("decode_code05", 32'({blue, green, red}), 32'({5'd31, 5'd0, 5'd31}));
    applyStimulus(7'h21, 7'h23, 2'b10, 7'h00, 1'b1, 1'b1, 4, 1'b0, 8'h00);
    applyStimulus(7'h10, 7'h30, 2'b11, 7'h7F, 1'b1, 1'b1, 4, 1'b0, 8'h00);
    applyStimulus(7'h15, 7'h26, 2'b00, 7'h7F, 1'b1, 1'b1, 4, 1'b0, 8'h00);

    // Horizontal and vertical blanking
    applyStimulus(7'h05, 7'h00, 2'b11, 7'h00, 1'b0, 1'b1, 4, 1'b0, 8'h00);
    applyStimulus(7'h05, 7'h00, 2'b11, 7'h00, 1'b1, 1'b1, 4, 1'b0, 8'h00);
    applyStimulus(7'h23, 7'h00, 2'b11, 7'h00, 1'b1, 1'b0, 4, 1'b0, 8'h00);
    applyStimulus(7'h41, 7'h00, 2'b01, 7'h00, 1'b1, 1'b1, 4, 1'b0, 8'h00);

    // Random pixels
    for (int n = 0; n < 8; n++) begin
      applyStimulus(7'($urandom), 7'($urandom), 2'($urandom), 7'($urandom),
                    1'b1, ($urandom_range(0, 3) != 0), 4, 1'b0, 8'h00);
    end

    // Collision: CPU overwrites 0x0A while the video port reads it
    applyStimulus(7'h05, 7'h00, 2'b01, 7'h00, 1'b1, 1'b1, 4, 1'b1, 8'h55);
    applyStimulus(7'h05, 7'h00, 2'b01, 7'h00, 1'b1, 1'b1, 4, 1'b0, 8'h00);
    checkOutput("collision_old_value", 32'({blue, green, red}), 32'({5'd31, 5'd0, 5'd31}));
    applyStimulus(7'h00, 7'h00, 2'b11, 7'h05, 1'b1, 1'b1, 4, 1'b0, 8'h00);
    checkOutput("new_value_after_write", 32'({blue, green, red}), 32'({5'd31, 5'd2, 5'd21}));

    // Fetch violation: strobes 2 clk apart
    checkOutput("fetch_err_before", 32'(fetch_err), 32'd0);
    applyStimulus(7'h23, 7'h00, 2'b01, 7'h00, 1'b1, 1'b1, 2, 1'b0, 8'h00);
    applyStimulus(7'h41, 7'h00, 2'b01, 7'h00, 1'b1, 1'b1, 2, 1'b0, 8'h00);
    checkOutput("fetch_err_set", 32'(fetch_err), 32'd1);
    applyStimulus(7'h62, 7'h00, 2'b01, 7'h00, 1'b1, 1'b1, 4, 1'b0, 8'h00);
    applyStimulus(7'h05, 7'h00, 2'b01, 7'h00, 1'b1, 1'b1, 4, 1'b0, 8'h00);
    checkOutput("fetch_err_sticky", 32'(fetch_err), 32'd1);

    // Asynchronous reset pulse mid-cycle
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_fetch_err", 32'(fetch_err), 32'd0);
    checkOutput("async_reset_rgb", 32'({blue, green, red}), 32'd0);
    tick();
    rst_n = 1'b1;
    sb.delete();
    sb.push_back('0);
    modelWord = '0;
    applyStimulus(7'h23, 7'h00, 2'b01, 7'h00, 1'b1, 1'b1, 4, 1'b0, 8'h00);
    applyStimulus(7'h05, 7'h00, 2'b01, 7'h00, 1'b1, 1'b1, 4, 1'b0, 8'h00);
    applyStimulus(7'h10, 7'h10, 2'b11, 7'h7F, 1'b1, 1'b1, 4, 1'b0, 8'h00);
    checkOutput("fetch_err_after_reset", 32'(fetch_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
